// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Execute-stage flag register and branch resolver.
//   * Captures the ALU condition flags {N,Z,C,V} on flag-setting instructions
//     (ADDS/SUBS/ANDS) that are not flushed.
//   * Resolves B.cond (ARM condition codes) and CBZ/CBNZ, and presents a
//     registered, single-cycle taken/not-taken decision to fetch.
//   * Keeps a saturating debug counter of taken branches.
//
// Parameters
//   FORWARD : 1 = a B.cond issued together with a flag write sees the new flags,
//             0 = it sees the flags stored before this instruction.
//   CNT_W   : width of the taken-branch counter.
//
// Ports
//   clk            system clock, rising-edge
//   reset          synchronous reset, active low
//   alu_zero       Z from the ALU result zero detector
//   alu_negative   bit 63 of the ALU result
//   alu_carry      ALU carry-out
//   alu_overflow   ALU signed overflow
//   set_flags      EX instruction writes flags
//   flush          squash the EX instruction (no flag write, no decision)
//   bcond_valid    B.cond in EX
//   cond           ARM condition code for B.cond
//   cbz_valid      CBZ/CBNZ in EX (wins over bcond_valid)
//   cbz_invert     0 = CBZ, 1 = CBNZ
//   rt_zero        zero-detect of the CBZ register operand
//   flags          stored {N,Z,C,V}
//   br_valid       registered decision strobe (one cycle per branch)
//   br_taken       registered taken bit, 0 whenever br_valid is 0
//   taken_count    saturating count of taken branches
// -----------------------------------------------------------------------------
module flag_branch_unit #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             set_flags,
  input  logic             flush,
  input  logic             bcond_valid,
  input  logic [3:0]       cond,
  input  logic             cbz_valid,
  input  logic             cbz_invert,
  input  logic             rt_zero,
  output logic [3:0]       flags,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  // State
  logic [3:0]       flags_q, flags_d;
  logic             br_valid_q, br_valid_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  // Combinational helpers
  logic       flag_wr;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       f_n, f_z, f_c, f_v;
  logic       cond_taken;
  logic       decision;
  logic       br_req;

  // ---------------------------------------------------------------------------
  // Flag register update
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};
    flag_wr   = set_flags & ~flush;
    flags_d   = flags_q;
    if (flag_wr) begin
      flags_d = alu_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Effective flags seen by B.cond. With forwarding, an instruction pair that
  // was fused into one EX slot (flag setter + B.cond) resolves against the
  // result it is producing instead of the stale register contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    eff_flags = flags_q;
    if (FORWARD && flag_wr) begin
      eff_flags = alu_flags;
    end
    {f_n, f_z, f_c, f_v} = eff_flags;
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation. 0xE (AL) and 0xF (NV) both mean "always" in ARMv8,
  // so they share the default arm.
  // ---------------------------------------------------------------------------
  always_comb begin
    cond_taken = 1'b1;
    case (cond)
      COND_EQ: cond_taken = f_z;
      COND_NE: cond_taken = ~f_z;
      COND_HS: cond_taken = f_c;
      COND_LO: cond_taken = ~f_c;
      COND_MI: cond_taken = f_n;
      COND_PL: cond_taken = ~f_n;
      COND_VS: cond_taken = f_v;
      COND_VC: cond_taken = ~f_v;
      COND_HI: cond_taken = f_c & ~f_z;
      COND_LS: cond_taken = ~f_c | f_z;
      COND_GE: cond_taken = (f_n == f_v);
      COND_LT: cond_taken = (f_n != f_v);
      COND_GT: cond_taken = ~f_z & (f_n == f_v);
      COND_LE: cond_taken = f_z | (f_n != f_v);
      default: cond_taken = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch decision. CBZ/CBNZ takes precedence over B.cond and never looks at
  // the flag register.
  // ---------------------------------------------------------------------------
  always_comb begin
    br_req   = (bcond_valid | cbz_valid) & ~flush;
    decision = cond_taken;
    if (cbz_valid) begin
      decision = rt_zero ^ cbz_invert;
    end
    br_valid_d = br_req;
    br_taken_d = br_req & decision;
  end

  // ---------------------------------------------------------------------------
  // Taken counter: counts the decision being registered on this edge and
  // sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    taken_count_d = taken_count_q;
    if (br_valid_d && br_taken_d && (taken_count_q != CNT_MAX)) begin
      taken_count_d = taken_count_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q       <= 4'b0000;
      br_valid_q    <= 1'b0;
      br_taken_q    <= 1'b0;
      taken_count_q <= '0;
    end else begin
      flags_q       <= flags_d;
      br_valid_q    <= br_valid_d;
      br_taken_q    <= br_taken_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign flags       = flags_q;
  assign br_valid    = br_valid_q;
  assign br_taken    = br_taken_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for flag_branch_unit.
// Three instances share the same stimulus:
//   u_dut  : FORWARD=1, CNT_W=32
//   u_fwd0 : FORWARD=0, CNT_W=32
//   u_sat  : FORWARD=1, CNT_W=4  (counter saturation)
// The driver pushes expected decisions into queues; a monitor pops and
// compares whenever a DUT presents br_valid.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       alu_zero, alu_negative, alu_carry, alu_overflow;
  logic       set_flags, flush, bcond_valid, cbz_valid, cbz_invert, rt_zero;
  logic [3:0] cond;

  logic [3:0]  flags1, flags0, flags_s;
  logic        br_valid1, br_valid0, br_valid_s;
  logic        br_taken1, br_taken0, br_taken_s;
  logic [31:0] count1, count0;
  logic [3:0]  count_s;

  flag_branch_unit #(.FORWARD(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .flush(flush),
    .bcond_valid(bcond_valid), .cond(cond),
    .cbz_valid(cbz_valid), .cbz_invert(cbz_invert), .rt_zero(rt_zero),
    .flags(flags1), .br_valid(br_valid1), .br_taken(br_taken1),
    .taken_count(count1)
  );

  flag_branch_unit #(.FORWARD(1'b0), .CNT_W(32)) u_fwd0 (
    .clk(clk), .reset(reset),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .flush(flush),
    .bcond_valid(bcond_valid), .cond(cond),
    .cbz_valid(cbz_valid), .cbz_invert(cbz_invert), .rt_zero(rt_zero),
    .flags(flags0), .br_valid(br_valid0), .br_taken(br_taken0),
    .taken_count(count0)
  );

  flag_branch_unit #(.FORWARD(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .flush(flush),
    .bcond_valid(bcond_valid), .cond(cond),
    .cbz_valid(cbz_valid), .cbz_invert(cbz_invert), .rt_zero(rt_zero),
    .flags(flags_s), .br_valid(br_valid_s), .br_taken(br_taken_s),
    .taken_count(count_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  m_flags;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  bit          known = 1'b0;
  logic        q1[$];
  logic        q0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Condition model grouped as ARM pairs: even code = base test, odd code =
  // its inverse, except 0xF which behaves like AL.
  function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) return ~base;
    return base;
  endfunction

  // One cycle of stimulus. At the start (negedge) the state produced by the
  // previous edge is compared against the model. f1/f0 >= 0 force a
  // hand-computed expected decision for u_dut / u_fwd0.
  task automatic drive(input logic r, input logic sf, input logic fl,
                       input logic [3:0] alu, input logic bv, input logic [3:0] cnd,
                       input logic cv, input logic inv, input logic rz,
                       input int f1, input int f0);
    logic wr, d1, d0;
    logic [3:0] eff1;
    @(negedge clk);
    if (known) begin
      chk("flags_fwd1", {28'd0, flags1}, {28'd0, m_flags});
      chk("flags_fwd0", {28'd0, flags0}, {28'd0, m_flags});
      chk("count32", count1, m_cnt);
      chk("count4", {28'd0, count_s}, {28'd0, m_cnt4});
    end
    reset = r; set_flags = sf; flush = fl;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = alu;
    bcond_valid = bv; cond = cnd; cbz_valid = cv; cbz_invert = inv; rt_zero = rz;
    if (!r) begin
      m_flags = 4'b0000; m_cnt = 32'd0; m_cnt4 = 4'd0; known = 1'b1;
    end else begin
      wr   = sf & ~fl;
      eff1 = wr ? alu : m_flags;
      if ((bv | cv) & ~fl) begin
        d1 = cv ? (rz ^ inv) : ref_taken(eff1, cnd);
        d0 = cv ? (rz ^ inv) : ref_taken(m_flags, cnd);
        if (f1 >= 0) d1 = f1[0];
        if (f0 >= 0) d0 = f0[0];
        q1.push_back(d1);
        q0.push_back(d0);
        if (d1) begin
          m_cnt = m_cnt + 32'd1;
          if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
        end
      end
      if (wr) m_flags = alu;
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic load(input logic [3:0] f);
    drive(1'b1, 1'b1, 1'b0, f, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic bcond(input logic [3:0] c, input int f1, input int f0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, c, 1'b0, 1'b0, 1'b0, f1, f0);
  endtask

  // Monitor: one line per decision seen, checked against the queue heads.
  always @(posedge clk) begin
    logic e;
    #1;
    if (br_valid1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_br_fwd1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        $display("decision fwd1: taken=%0b expected=%0b", br_taken1, e);
        chk("br_taken_fwd1", {31'd0, br_taken1}, {31'd0, e});
      end
    end else if (q1.size() != 0) begin
      void'(q1.pop_front());
      chk("missing_br_fwd1", {31'd0, br_valid1}, 32'd1);
    end
    if (br_valid0 === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_br_fwd0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("br_taken_fwd0", {31'd0, br_taken0}, {31'd0, e});
      end
    end else if (q0.size() != 0) begin
      void'(q0.pop_front());
      chk("missing_br_fwd0", {31'd0, br_valid0}, 32'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; set_flags = 1'b0; flush = 1'b0;
    alu_zero = 1'b0; alu_negative = 1'b0; alu_carry = 1'b0; alu_overflow = 1'b0;
    bcond_valid = 1'b0; cond = 4'h0; cbz_valid = 1'b0; cbz_invert = 1'b0; rt_zero = 1'b0;

    // 1. Reset with random inputs, then first flag write
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), -1, -1);
    idle();
    chk("reset_flags", {28'd0, flags1}, 32'd0);
    chk("reset_br_valid", {31'd0, br_valid1}, 32'd0);
    chk("reset_br_taken", {31'd0, br_taken1}, 32'd0);
    chk("reset_count", count1, 32'd0);
    load(4'b1010);
    idle();
    chk("first_flags", {28'd0, flags1}, 32'hA);

    // 2. All 16 codes against all 16 flag combinations
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        load(f[3:0]);
        bcond(c[3:0], -1, -1);
      end
    end
    load(4'b0110); bcond(4'h8, 0, 0);   // HI with C=1,Z=1 -> not taken
    load(4'b1001); bcond(4'hA, 1, 1);   // GE with N=V=1 -> taken
    load(4'b0101); bcond(4'hD, 1, 1);   // LE with Z=1 -> taken
    load(4'b1000); bcond(4'hC, 0, 0);   // GT with N!=V -> not taken

    // 3. Forwarding: stored Z=0, same-cycle write of Z=1 with B.EQ
    load(4'b0000);
    drive(1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    idle();
    chk("fwd_flags_fwd1", {28'd0, flags1}, 32'h4);
    chk("fwd_flags_fwd0", {28'd0, flags0}, 32'h4);

    // 4. CBZ/CBNZ and priority over B.cond
    load(4'b1011);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1, 1);  // CBZ, zero
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 0, 0);  // CBNZ, zero
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 0, 0);  // CBZ beats AL
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1, 1);  // CBNZ beats EQ(Z=0)
    idle();
    chk("cbz_flags_kept", {28'd0, flags1}, 32'hB);

    // 5. Flush: no flag write, no decision; a registered decision survives
    drive(1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, -1, -1);
    idle();
    chk("flush_flags", {28'd0, flags1}, 32'hB);
    chk("flush_br_valid", {31'd0, br_valid1}, 32'd0);
    bcond(4'hE, 1, 1);
    drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("flush_keeps_decision", {31'd0, br_valid1}, 32'd1);
    idle();

    // 6. Saturation of the 4-bit counter, then reset mid-burst
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 20; i++) bcond(4'hE, 1, 1);
    idle();
    chk("sat_count", {28'd0, count_s}, 32'hF);
    chk("nosat_count32", count1, 32'd20);
    for (int i = 0; i < 3; i++) bcond(4'hE, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, -1, -1);
    idle();
    chk("midreset_count4", {28'd0, count_s}, 32'd0);
    chk("midreset_count32", count1, 32'd0);
    chk("midreset_br_valid", {31'd0, br_valid1}, 32'd0);

    idle();
    idle();
    chk("queues_drained", q1.size() + q0.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the 64-bit zero detector and the ALU in the execute stage.
- Latches the ALU condition flags N, Z, C and V into an architectural flag register on flag-setting instructions (ADDS, SUBS, ANDS).
- Evaluates the branch condition for B.cond and CBZ/CBNZ, and issues a registered taken/not-taken decision to the fetch/PC logic.
- Keeps a saturating count of taken branches for debug.

Parameters:
FORWARD, 1, 1 = a B.cond in the same cycle as a flag write evaluates against the incoming flags; 0 = it evaluates against the stored flags.
CNT_W, 32, width of the taken-branch counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
alu_zero  input  1  Z from the zero detector of the ALU result
alu_negative  input  1  bit 63 of the ALU result
alu_carry  input  1  ALU carry-out
alu_overflow  input  1  ALU signed overflow
set_flags  input  1  current EX instruction writes flags
flush  input  1  squash the EX instruction; suppresses flag write and branch evaluation this cycle
bcond_valid  input  1  B.cond in EX
cond  input  4  ARM condition code for B.cond
cbz_valid  input  1  CBZ/CBNZ in EX
cbz_invert  input  1  0 = CBZ (taken if zero), 1 = CBNZ
rt_zero  input  1  zero-detect result of the CBZ register operand
flags  output  4  stored {N,Z,C,V}
br_valid  output  1  registered: a branch decision is present
br_taken  output  1  registered: branch taken (meaningful only when br_valid=1)
taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset: when reset=0 at a rising edge, flags=4'b0000, br_valid=0, br_taken=0, taken_count=0. Reset overrides every other input, including a reset asserted mid-operation; a decision pending from the prior cycle is dropped.
- Flag write: when set_flags=1 and flush=0 at an edge, flags <= {alu_negative, alu_zero, alu_carry, alu_overflow}. Otherwise flags hold.
- Effective flags F for B.cond:
  - F = incoming ALU flags if FORWARD=1, set_flags=1 and flush=0.
  - F = stored flags in every other case.
- Condition table (cond -> taken):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 1 (AL behaviour, per ARMv8)
- CBZ decision: taken = rt_zero XOR cbz_invert. Stored flags are neither read nor written.
- Priority: if cbz_valid and bcond_valid are both 1, the CBZ decision is used and cond is ignored.
- Decision register, 1-cycle latency:
  - At the next edge, br_valid <= (bcond_valid|cbz_valid) & !flush.
  - br_taken <= the computed decision when br_valid is set, else 0.
  - Each decision is a single-cycle pulse; back-to-back requests give back-to-back pulses with no bubble.
- Counter: increments by 1 on every edge where the newly registered br_valid=1 and br_taken=1. It saturates at 2^CNT_W-1 and never wraps.
- flush: has no effect on stored flags from earlier cycles, and no effect on a decision already registered.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with all inputs randomised -> flags=0000, br_valid=0, br_taken=0, taken_count=0. Then reset=1 and set_flags=1 with ALU flags N1 Z0 C1 V0 -> flags=4'b1010 after one edge.
2. All 16 codes: for each cond 0..F, preload each of the 16 flag combinations via set_flags, then pulse bcond_valid -> br_taken matches the table one cycle later. Examples: flags 0110, cond 8 (HI) -> 0; flags 1001, cond A (GE) -> 1.
3. Forwarding: stored Z=0, then the same cycle has set_flags=1, alu_zero=1, bcond_valid=1, cond=0 (EQ) -> br_taken=1 with FORWARD=1, br_taken=0 with FORWARD=0. flags Z=1 afterwards in both cases.
4. CBZ/CBNZ and priority:
   - rt_zero=1, cbz_invert=0 -> taken.
   - cbz_invert=1 -> not taken.
   - Both cbz_valid and bcond_valid with cond=E -> the CBZ result wins.
   - Stored flags are unchanged in all cases.
5. Flush: set_flags=1 with new flags and bcond_valid=1, flush=1 -> flags unchanged, br_valid=0 on the next cycle, counter unchanged.
6. Counter saturation with CNT_W=4: 20 consecutive taken branches (cond=E) -> taken_count reaches 15 and stays 15. Assert reset=0 mid-burst -> taken_count=0 and br_valid=0 on the following cycle.
